diff_commit_sequencer: RTL and testbench

- Sits between the multi-lane commit stage and the difftest bridge.
- Each cycle it accepts up to LANES commit/exception records and buffers them in program order in a FIFO.
- It replays them to the bridge one per cycle, tagging each with a wrapping sequence index.
- A halt request drains the buffer, then signals done so the harness can stop the simulation cleanly.

---
 rtl/diff_pkg.sv | 15 +
 rtl/diff_rec_fifo.sv | 39 +++
 rtl/diff_commit_sequencer.sv | 101 ++++++++++
 tb/tb_diff_commit_sequencer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/diff_pkg.sv
// diff_pkg: shared record type, sequencer states and sequence width
package diff_pkg;
    localparam int SEQ_W = 8;
    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;
    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        skip;
        logic        wen;
        logic [7:0]  wdest;
        logic [63:0] wdata;
        logic        excp;
        logic [31:0] cause;
    } commit_rec_t;
endpackage

// File: rtl/diff_rec_fifo.sv
// diff_rec_fifo: multi-write (up to LANES, pre-compacted) single-read record FIFO with occupancy count
// Ports: clock/reset, wr_n_i = number of records written from wr_rec_i[0..], rd_i pops head_o, count_o = occupancy
module diff_rec_fifo
    import diff_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int LANES = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int NW = $clog2(LANES + 1)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NW-1:0]                 wr_n_i,
    input  commit_rec_t [LANES-1:0]       wr_rec_i,
    input  logic                          rd_i,
    output commit_rec_t                   head_o,
    output logic [AW:0]                   count_o
);
    commit_rec_t mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0] cnt_q;
    always_ff @(posedge clock) begin
        for (int i = 0; i < LANES; i++)
            if (NW'(i) < wr_n_i) mem_q[wr_q + AW'(i)] <= wr_rec_i[i];
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_q + AW'(wr_n_i);
            rd_q  <= rd_q + AW'(rd_i);
            cnt_q <= cnt_q + (AW+1)'(wr_n_i) - (AW+1)'(rd_i);
        end
    end
    assign head_o  = mem_q[rd_q];
    assign count_o = cnt_q;
endmodule

// File: rtl/diff_commit_sequencer.sv
// diff_commit_sequencer: buffers multi-lane commit records in program order and replays them one per cycle with a sequence index
// Ports: per-lane in_* record buses with in_valid/in_ready, halt starts drain, out_* head record with out_valid/out_ready,
//        out_index wrapping sequence, done one-cycle pulse at drain end, overflow sticky protocol-violation flag
module diff_commit_sequencer
    import diff_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int LANES = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [LANES-1:0]      in_valid,
    input  logic [64*LANES-1:0]   in_pc,
    input  logic [32*LANES-1:0]   in_instr,
    input  logic [LANES-1:0]      in_skip,
    input  logic [LANES-1:0]      in_wen,
    input  logic [8*LANES-1:0]    in_wdest,
    input  logic [64*LANES-1:0]   in_wdata,
    input  logic [LANES-1:0]      in_excp,
    input  logic [32*LANES-1:0]   in_cause,
    output logic                  in_ready,
    input  logic                  halt,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SEQ_W-1:0]      out_index,
    output logic [63:0]           out_pc,
    output logic [31:0]           out_instr,
    output logic                  out_skip,
    output logic                  out_wen,
    output logic [7:0]            out_wdest,
    output logic [63:0]           out_wdata,
    output logic                  out_excp,
    output logic [31:0]           out_cause,
    output logic                  done,
    output logic                  overflow
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int NW = $clog2(LANES + 1);
    state_t state_q, state_d;
    logic [SEQ_W-1:0] seq_q;
    logic done_q, ovf_q, deq;
    logic [CW-1:0] cnt;
    logic [NW-1:0] wr_n;
    commit_rec_t [LANES-1:0] lane_rec, wr_rec;
    commit_rec_t head, out_rec;
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign lane_rec[g] = '{pc: in_pc[64*g +: 64], instr: in_instr[32*g +: 32], skip: in_skip[g],
                               wen: in_wen[g], wdest: in_wdest[8*g +: 8], wdata: in_wdata[64*g +: 64],
                               excp: in_excp[g], cause: in_cause[32*g +: 32]};
    end
    // Compaction: slot 0 takes lane 0 if valid, else the upper lane; slot 1 only ever holds lane 1.
    assign wr_rec[0] = in_valid[0] ? lane_rec[0] : lane_rec[LANES-1];
    if (LANES == 2) begin : g_slot1
        assign wr_rec[1] = lane_rec[1];
    end
    assign in_ready  = (state_q == RUN) && (cnt <= CW'(DEPTH - LANES));
    assign wr_n      = in_ready ? NW'($countones(in_valid)) : '0;
    assign out_valid = (cnt != '0) && (state_q != DONE);
    assign deq       = out_valid && out_ready;
    diff_rec_fifo #(.DEPTH(DEPTH), .LANES(LANES)) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .wr_n_i  (wr_n),
        .wr_rec_i(wr_rec),
        .rd_i    (deq),
        .head_o  (head),
        .count_o (cnt)
    );
    // Storage is not reset, so the head is masked to keep out_* at zero while nothing is presented.
    assign out_rec   = out_valid ? head : '0;
    assign out_pc    = out_rec.pc;
    assign out_instr = out_rec.instr;
    assign out_skip  = out_rec.skip;
    assign out_wen   = out_rec.wen;
    assign out_wdest = out_rec.wdest;
    assign out_wdata = out_rec.wdata;
    assign out_excp  = out_rec.excp;
    assign out_cause = out_rec.cause;
    assign out_index = seq_q;
    assign done      = done_q;
    assign overflow  = ovf_q;
    // No enqueue happens in DRAIN, so the buffer empties when count is zero or the last entry is popped.
    always_comb begin
        state_d = state_q;
        state_d = (state_q == RUN && halt) ? DRAIN :
                  (state_q == DRAIN && (cnt == '0 || (cnt == CW'(1) && deq))) ? DONE : state_q;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= RUN;
            seq_q   <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            seq_q   <= seq_q + SEQ_W'(deq);
            done_q  <= (state_d == DONE) && (state_q != DONE);
            ovf_q   <= ovf_q | ((|in_valid) && !in_ready);
        end
    end
endmodule

// File: tb/tb_diff_commit_sequencer.sv
// tb_diff_commit_sequencer: directed self-checking bench for diff_commit_sequencer
module tb_diff_commit_sequencer;
    logic         clock = 1'b0;
    logic         reset;
    logic [1:0]   in_valid;
    logic [127:0] in_pc;
    logic [63:0]  in_instr;
    logic [1:0]   in_skip;
    logic [1:0]   in_wen;
    logic [15:0]  in_wdest;
    logic [127:0] in_wdata;
    logic [1:0]   in_excp;
    logic [63:0]  in_cause;
    logic         in_ready;
    logic         halt;
    logic         out_valid;
    logic         out_ready;
    logic [7:0]   out_index;
    logic [63:0]  out_pc;
    logic [31:0]  out_instr;
    logic         out_skip;
    logic         out_wen;
    logic [7:0]   out_wdest;
    logic [63:0]  out_wdata;
    logic         out_excp;
    logic [31:0]  out_cause;
    logic         done;
    logic         overflow;
    int vectors = 0;
    int miscompares = 0;

    diff_commit_sequencer #(.DEPTH(8), .LANES(2)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr),
        .in_skip(in_skip), .in_wen(in_wen), .in_wdest(in_wdest), .in_wdata(in_wdata),
        .in_excp(in_excp), .in_cause(in_cause), .in_ready(in_ready), .halt(halt),
        .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index), .out_pc(out_pc),
        .out_instr(out_instr), .out_skip(out_skip), .out_wen(out_wen), .out_wdest(out_wdest),
        .out_wdata(out_wdata), .out_excp(out_excp), .out_cause(out_cause), .done(done),
        .overflow(overflow)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_in();
        in_valid = '0; in_pc = '0; in_instr = '0; in_skip = '0; in_wen = '0;
        in_wdest = '0; in_wdata = '0; in_excp = '0; in_cause = '0;
    endtask

    task automatic do_reset();
        clear_in();
        halt = 1'b0; out_ready = 1'b0; reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        vectors++; if (done !== 1'b0 || overflow !== 1'b0) begin miscompares++; $display("FAIL reset_flags: done=%b overflow=%b want 0 0", done, overflow); end
        vectors++; if (out_pc !== 64'h0 || out_index !== 8'h0) begin miscompares++; $display("FAIL reset_data: pc=%h index=%0d want 0 0", out_pc, out_index); end
    endtask

    task automatic test_two_lane();
        do_reset();
        out_ready = 1'b1;
        in_valid = 2'b11;
        in_pc = {64'h8000_0004, 64'h8000_0000};
        tick();
        clear_in();
        vectors++; if (out_valid !== 1'b1 || out_pc !== 64'h8000_0000 || out_index !== 8'd0) begin miscompares++; $display("FAIL two_lane_rec0: valid=%b pc=%h idx=%0d want 1 80000000 0", out_valid, out_pc, out_index); end
        tick();
        vectors++; if (out_valid !== 1'b1 || out_pc !== 64'h8000_0004 || out_index !== 8'd1) begin miscompares++; $display("FAIL two_lane_rec1: valid=%b pc=%h idx=%0d want 1 80000004 1", out_valid, out_pc, out_index); end
        tick();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL two_lane_empty: valid=%b want 0", out_valid); end
    endtask

    task automatic test_lane1_only();
        do_reset();
        out_ready = 1'b1;
        in_valid = 2'b10;
        in_pc[127:64] = 64'h8000_0010;
        in_wen = 2'b10;
        in_wdest[15:8] = 8'd5;
        in_wdata[127:64] = 64'hdead;
        tick();
        clear_in();
        vectors++; if (out_valid !== 1'b1 || out_pc !== 64'h8000_0010 || out_index !== 8'd0) begin miscompares++; $display("FAIL lane1_rec: valid=%b pc=%h idx=%0d want 1 80000010 0", out_valid, out_pc, out_index); end
        vectors++; if (out_wen !== 1'b1 || out_wdest !== 8'd5 || out_wdata !== 64'hdead) begin miscompares++; $display("FAIL lane1_wb: wen=%b wdest=%0d wdata=%h want 1 5 dead", out_wen, out_wdest, out_wdata); end
        vectors++; if (out_excp !== 1'b0 || out_skip !== 1'b0) begin miscompares++; $display("FAIL lane1_flags: excp=%b skip=%b want 0 0", out_excp, out_skip); end
        tick();
        vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL lane1_drained: valid=%b in_ready=%b want 0 1", out_valid, in_ready); end
    endtask

    task automatic test_backpressure();
        logic [63:0] exp_pc [8];
        do_reset();
        for (int g = 0; g < 4; g++) begin
            vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_ready_g%0d: got %b want 1", g, in_ready); end
            in_valid = 2'b11;
            in_pc = {64'h100 + 64'(16*g + 8), 64'h100 + 64'(16*g)};
            exp_pc[2*g] = 64'h100 + 64'(16*g);
            exp_pc[2*g+1] = 64'h100 + 64'(16*g + 8);
            if (g == 1) begin in_excp = 2'b10; in_cause = {32'hb, 32'h0}; end
            tick();
            clear_in();
        end
        vectors++; if (in_ready !== 1'b0 || overflow !== 1'b0) begin miscompares++; $display("FAIL bp_full: in_ready=%b overflow=%b want 0 0", in_ready, overflow); end
        vectors++; if (out_pc !== 64'h100 || out_index !== 8'd0) begin miscompares++; $display("FAIL bp_hold: pc=%h idx=%0d want 100 0", out_pc, out_index); end
        in_valid = 2'b11;
        in_pc = {64'h999, 64'h998};
        tick();
        clear_in();
        vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL bp_overflow: got %b want 1", overflow); end
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            vectors++; if (out_valid !== 1'b1 || out_pc !== exp_pc[k] || out_index !== 8'(k)) begin miscompares++; $display("FAIL bp_drain%0d: valid=%b pc=%h idx=%0d want 1 %h %0d", k, out_valid, out_pc, out_index, exp_pc[k], k); end
            if (k == 3) begin
                vectors++; if (out_excp !== 1'b1 || out_cause !== 32'hb) begin miscompares++; $display("FAIL bp_excp: excp=%b cause=%h want 1 b", out_excp, out_cause); end
            end
            tick();
            if (k == 0) begin
                vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_count7_ready: got %b want 0", in_ready); end
            end
            if (k == 1) begin
                vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_count6_ready: got %b want 1", in_ready); end
            end
        end
        vectors++; if (out_valid !== 1'b0 || overflow !== 1'b1) begin miscompares++; $display("FAIL bp_end: valid=%b overflow=%b want 0 1", out_valid, overflow); end
    endtask

    task automatic test_index_wrap();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            in_valid = 2'b01;
            in_pc[63:0] = 64'(i * 4);
            tick();
            clear_in();
            vectors++; if (out_valid !== 1'b1 || out_pc !== 64'(i * 4) || out_index !== 8'(i)) begin miscompares++; $display("FAIL wrap_rec%0d: valid=%b pc=%h idx=%0d want 1 %h %0d", i, out_valid, out_pc, out_index, 64'(i * 4), i % 256); end
        end
        tick();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL wrap_end: valid=%b want 0", out_valid); end
    endtask

    task automatic test_halt_drain();
        int emitted;
        int pulses;
        logic [63:0] exp_pc [3];
        exp_pc[0] = 64'h200; exp_pc[1] = 64'h204; exp_pc[2] = 64'h208;
        do_reset();
        in_valid = 2'b11; in_pc = {64'h204, 64'h200};
        tick();
        in_valid = 2'b01; in_pc = {64'h0, 64'h208};
        tick();
        clear_in();
        halt = 1'b1; out_ready = 1'b1;
        vectors++; if (out_pc !== 64'h200 || in_ready !== 1'b1) begin miscompares++; $display("FAIL halt_first: pc=%h in_ready=%b want 200 1", out_pc, in_ready); end
        tick();
        halt = 1'b0;
        emitted = 1;
        pulses = 0;
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL halt_in_ready: got %b want 0", in_ready); end
        for (int c = 0; c < 8; c++) begin
            if (done === 1'b1) pulses++;
            if (out_valid === 1'b1) begin
                vectors++; if (emitted > 2 || out_pc !== exp_pc[emitted]) begin miscompares++; $display("FAIL halt_rec%0d: pc=%h", emitted, out_pc); end
                emitted++;
            end
            tick();
        end
        vectors++; if (emitted !== 3) begin miscompares++; $display("FAIL halt_count: got %0d want 3", emitted); end
        vectors++; if (pulses !== 1) begin miscompares++; $display("FAIL halt_done_pulses: got %0d want 1", pulses); end
        vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL halt_terminal: valid=%b in_ready=%b done=%b want 0 0 0", out_valid, in_ready, done); end
    endtask

    task automatic test_reset_mid_drain();
        int pulses;
        do_reset();
        in_valid = 2'b11; in_pc = {64'h304, 64'h300};
        tick();
        clear_in();
        halt = 1'b1;
        tick();
        halt = 1'b0;
        vectors++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin miscompares++; $display("FAIL mid_drain_state: valid=%b in_ready=%b want 1 0", out_valid, in_ready); end
        pulses = 0;
        reset = 1'b1;
        tick();
        if (done === 1'b1) pulses++;
        reset = 1'b0;
        vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL mid_reset_out: valid=%b in_ready=%b want 0 1", out_valid, in_ready); end
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (done === 1'b1) pulses++;
        end
        vectors++; if (pulses !== 0) begin miscompares++; $display("FAIL mid_reset_done: got %0d pulses want 0", pulses); end
        in_valid = 2'b01; in_pc[63:0] = 64'h400;
        tick();
        clear_in();
        vectors++; if (out_valid !== 1'b1 || out_pc !== 64'h400 || out_index !== 8'd0) begin miscompares++; $display("FAIL mid_reset_restart: valid=%b pc=%h idx=%0d want 1 400 0", out_valid, out_pc, out_index); end
    endtask

    initial begin
        clear_in();
        halt = 1'b0; out_ready = 1'b0; reset = 1'b1;
        test_reset();
        test_two_lane();
        test_lane1_only();
        test_backpressure();
        test_index_wrap();
        test_halt_drain();
        test_reset_mid_drain();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
